// File: rtl/apo_input_arbiter.sv
// apo_input_arbiter: five one-entry holding slots feeding a single output
// register through a round-robin scheduler. Colliding arrivals are dropped,
// flagged per port and counted (saturating).

// One holding slot: loads an arriving packet when empty or draining this edge.
module apo_hold_slot #(
  parameter int N2 = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N2-1:0] in_pkt,
  input  logic          move,
  output logic          full,
  output logic [N2-1:0] pkt,
  output logic          drop
);
  logic          full_q, full_d;
  logic [N2-1:0] pkt_q, pkt_d;
  logic          arrive, load;

  // Arrival resolves to a load or a drop; a move frees the slot for reuse.
  always_comb begin
    arrive = in_pkt[N2-1];
    load   = arrive && (!full_q || move);
    drop   = arrive && full_q && !move;
    full_d = load || (full_q && !move);
    pkt_d  = load ? in_pkt : pkt_q;
  end

  // Slot state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      pkt_q  <= '0;
    end else begin
      full_q <= full_d;
      pkt_q  <= pkt_d;
    end
  end

  assign full = full_q;
  assign pkt  = pkt_q;
endmodule

module apo_input_arbiter #(
  parameter int N2 = 9,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N2-1:0] in_free,
  input  logic [N2-1:0] in_r1R,
  input  logic [N2-1:0] in_r2R,
  input  logic [N2-1:0] in_r1L,
  input  logic [N2-1:0] in_r2L,
  output logic [N2-1:0] grant_pkt,
  output logic [2:0]    grant_src,
  output logic          grant_valid,
  input  logic          grant_ready,
  output logic [4:0]    hold_full,
  output logic [4:0]    drop_err,
  output logic [CW-1:0] drop_count,
  input  logic          clr_err
);
  localparam int NP = 5;

  logic [NP-1:0][N2-1:0] in_bus, slot_pkt;
  logic [NP-1:0]         move, drop;

  logic [N2-1:0] grant_pkt_q, grant_pkt_d;
  logic [2:0]    grant_src_q, grant_src_d;
  logic          grant_valid_q, grant_valid_d;
  logic [2:0]    last_q, last_d;
  logic [4:0]    drop_err_q, drop_err_d;
  logic [CW-1:0] drop_count_q, drop_count_d;

  logic          out_load, sel_valid;
  logic [2:0]    sel_idx;
  logic [3:0]    cand;
  logic [2:0]    ndrop;
  logic [CW:0]   cnt_sum;
  logic [CW-1:0] cnt_base;

  assign in_bus = {in_r2L, in_r1L, in_r2R, in_r1R, in_free};

  for (genvar g = 0; g < NP; g++) begin : g_slot
    apo_hold_slot #(.N2(N2)) u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .in_pkt (in_bus[g]),
      .move   (move[g]),
      .full   (hold_full[g]),
      .pkt    (slot_pkt[g]),
      .drop   (drop[g])
    );
  end

  // Round-robin pick: first occupied slot after last, wrapping mod 5.
  always_comb begin
    out_load  = !grant_valid_q || grant_ready;
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NP; i++) begin
      cand = {1'b0, last_q} + 4'(i);
      if (cand >= 4'(NP)) cand = cand - 4'(NP);
      if (!sel_valid && hold_full[cand[2:0]]) begin
        sel_valid = 1'b1;
        sel_idx   = cand[2:0];
      end
    end
    move = '0;
    if (out_load && sel_valid) move[sel_idx] = 1'b1;
  end

  // Output stage and pointer advance only when the stage can take a packet.
  always_comb begin
    grant_pkt_d   = grant_pkt_q;
    grant_src_d   = grant_src_q;
    grant_valid_d = grant_valid_q;
    last_d        = last_q;
    if (out_load) begin
      grant_valid_d = sel_valid;
      if (sel_valid) begin
        grant_pkt_d = slot_pkt[sel_idx];
        grant_src_d = sel_idx;
        last_d      = sel_idx;
      end
    end
  end

  // Drop bookkeeping; a same-edge drop survives a clear.
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NP; i++) ndrop = ndrop + {2'b00, drop[i]};
    cnt_base     = clr_err ? '0 : drop_count_q;
    cnt_sum      = {1'b0, cnt_base} + (CW+1)'(ndrop);
    drop_count_d = cnt_sum[CW] ? '1 : cnt_sum[CW-1:0];
    drop_err_d   = (clr_err ? 5'b0 : drop_err_q) | drop;
  end

  // State registers; last resets to 4 so port 0 wins first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_pkt_q   <= '0;
      grant_src_q   <= '0;
      grant_valid_q <= 1'b0;
      last_q        <= 3'd4;
      drop_err_q    <= '0;
      drop_count_q  <= '0;
    end else begin
      grant_pkt_q   <= grant_pkt_d;
      grant_src_q   <= grant_src_d;
      grant_valid_q <= grant_valid_d;
      last_q        <= last_d;
      drop_err_q    <= drop_err_d;
      drop_count_q  <= drop_count_d;
    end
  end

  assign grant_pkt   = grant_pkt_q;
  assign grant_src   = grant_src_q;
  assign grant_valid = grant_valid_q;
  assign drop_err    = drop_err_q;
  assign drop_count  = drop_count_q;
endmodule

// File: tb/tb_apo_input_arbiter.sv
// Bench for apo_input_arbiter: directed scenarios plus randomized traffic,
// all checked every cycle against a behavioural model of the arbiter.
module tb_apo_input_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] in_pkt [5];
  logic       grant_ready = 1'b1;
  logic       clr_err = 1'b0;
  logic [8:0] grant_pkt;
  logic [2:0] grant_src;
  logic       grant_valid;
  logic [4:0] hold_full, drop_err;
  logic [7:0] drop_count;

  int n_vec = 0;
  int n_err = 0;

  // behavioural model state
  bit   [4:0] m_full;
  logic [8:0] m_pkt [5];
  bit         m_gv;
  logic [8:0] m_gp;
  int         m_gs, m_last, m_cnt;
  bit   [4:0] m_err;

  always #5 clk = ~clk;

  apo_input_arbiter #(.N2(9), .CW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_free(in_pkt[0]), .in_r1R(in_pkt[1]), .in_r2R(in_pkt[2]),
    .in_r1L(in_pkt[3]), .in_r2L(in_pkt[4]),
    .grant_pkt(grant_pkt), .grant_src(grant_src), .grant_valid(grant_valid),
    .grant_ready(grant_ready), .hold_full(hold_full), .drop_err(drop_err),
    .drop_count(drop_count), .clr_err(clr_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = '0; m_gv = 0; m_gp = '0; m_gs = 0; m_last = 4; m_cnt = 0; m_err = '0;
    for (int p = 0; p < 5; p++) m_pkt[p] = '0;
  endtask

  task automatic clear_inputs();
    for (int p = 0; p < 5; p++) in_pkt[p] = '0;
    clr_err = 0;
  endtask

  task automatic chk_all();
    chk("hold_full", 32'(hold_full), 32'(m_full));
    chk("grant_valid", 32'(grant_valid), 32'(m_gv));
    chk("grant_pkt", 32'(grant_pkt), 32'(m_gp));
    chk("grant_src", 32'(grant_src), 32'(m_gs));
    chk("drop_err", 32'(drop_err), 32'(m_err));
    chk("drop_count", 32'(drop_count), 32'(m_cnt));
  endtask

  // One clock edge: predict from the rules, advance, compare everything.
  task automatic step();
    bit   [4:0] n_full = m_full;
    logic [8:0] n_pkt [5];
    bit         n_gv = m_gv;
    logic [8:0] n_gp = m_gp;
    int         n_gs = m_gs, n_last = m_last, sel = -1, nd = 0, base;
    bit   [4:0] dmask = '0;
    for (int p = 0; p < 5; p++) n_pkt[p] = m_pkt[p];
    if (!m_gv || grant_ready) begin
      for (int k = 1; k <= 5; k++)
        if (sel < 0 && m_full[(m_last + k) % 5]) sel = (m_last + k) % 5;
      n_gv = (sel >= 0);
      if (sel >= 0) begin
        n_gp = m_pkt[sel]; n_gs = sel; n_last = sel; n_full[sel] = 0;
      end
    end
    for (int p = 0; p < 5; p++)
      if (in_pkt[p][8]) begin
        if (!m_full[p] || p == sel) begin n_full[p] = 1; n_pkt[p] = in_pkt[p]; end
        else begin dmask[p] = 1; nd++; end
      end
    base = clr_err ? 0 : m_cnt;
    @(posedge clk); #1;
    m_full = n_full; m_gv = n_gv; m_gp = n_gp; m_gs = n_gs; m_last = n_last;
    for (int p = 0; p < 5; p++) m_pkt[p] = n_pkt[p];
    m_cnt = (base + nd > 255) ? 255 : base + nd;
    m_err = (clr_err ? 5'b0 : m_err) | dmask;
    chk_all();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 0; #2;
    model_reset();
    chk("rst_valid", 32'(grant_valid), 32'd0);
    chk("rst_hold", 32'(hold_full), 32'd0);
    chk("rst_cnt", 32'(drop_count), 32'd0);
    rst_n = 1;
  endtask

  initial begin
    int grants;
    int exp_src;
    clear_inputs();
    model_reset();
    #3;
    chk_all();
    @(negedge clk); rst_n = 1;

    // single packet on port 2
    in_pkt[2] = 9'h121; step();
    chk("single_hold", 32'(hold_full), 32'h04);
    in_pkt[2] = '0; step();
    chk("single_gv", 32'(grant_valid), 32'd1);
    chk("single_pkt", 32'(grant_pkt), 32'h121);
    chk("single_src", 32'(grant_src), 32'd2);
    step();
    chk("single_gv_off", 32'(grant_valid), 32'd0);

    // all five ports at once
    do_reset();
    for (int p = 0; p < 5; p++) in_pkt[p] = 9'(9'h101 + p);
    step(); clear_inputs();
    for (int p = 0; p < 5; p++) begin
      step();
      chk("all5_src", 32'(grant_src), 32'(p));
      chk("all5_pkt", 32'(grant_pkt), 32'(9'h101 + p));
    end
    chk("all5_nodrop", 32'(drop_count), 32'd0);

    // round-robin between ports 0 and 3
    do_reset();
    grants = 0; exp_src = 0;
    for (int c = 0; c < 14; c++) begin
      in_pkt[0] = m_full[0] ? 9'h0 : 9'(9'h100 | c);
      in_pkt[3] = m_full[3] ? 9'h0 : 9'(9'h180 | c);
      step();
      if (grant_valid) begin
        chk("rr_src", 32'(grant_src), 32'(exp_src));
        exp_src = (exp_src == 0) ? 3 : 0;
        grants++;
      end
    end
    clear_inputs();
    chk("rr_grants", 32'(grants >= 8), 32'd1);
    chk("rr_nodrop", 32'(drop_err), 32'd0);

    // backpressure and drop
    do_reset();
    grant_ready = 0;
    in_pkt[0] = 9'h1AA; step();
    in_pkt[0] = '0; in_pkt[1] = 9'h111; step();
    chk("bp_pkt0", 32'(grant_pkt), 32'h1AA);
    in_pkt[1] = 9'h122; step();
    in_pkt[1] = '0;
    chk("bp_err", 32'(drop_err), 32'h02);
    chk("bp_cnt", 32'(drop_count), 32'd1);
    step(); step();
    chk("bp_stable", 32'(grant_pkt), 32'h1AA);
    grant_ready = 1; step();
    chk("bp_next", 32'(grant_pkt), 32'h111);
    grant_ready = 0;

    // clear versus drop on port 4
    in_pkt[4] = 9'h144; step();
    step(); step();
    chk("cd_pre", 32'(drop_count), 32'd3);
    clr_err = 1; step();
    clr_err = 0; in_pkt[4] = '0;
    chk("cd_err", 32'(drop_err), 32'h10);
    chk("cd_cnt", 32'(drop_count), 32'd1);

    // saturate the drop counter
    for (int c = 0; c < 60; c++) begin
      for (int p = 0; p < 5; p++) in_pkt[p] = 9'(9'h100 | $urandom_range(255));
      step();
    end
    chk("sat_cnt", 32'(drop_count), 32'hFF);
    clear_inputs(); grant_ready = 1;

    // randomized traffic with one mid-run reset
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 5; p++)
        in_pkt[p] = 9'(($urandom_range(1) << 8) | $urandom_range(255));
      grant_ready = ($urandom_range(9) < 7);
      clr_err = ($urandom_range(19) == 0);
      if (c == 200) begin
        do_reset();
        chk("midrst_gv", 32'(grant_valid), 32'd0);
        chk("midrst_pkt", 32'(grant_pkt), 32'd0);
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/apo_input_arbiter.md
# apo_input_arbiter

Input-side arbiter for one node of the circulant NoC (C(9; 2, 3) build). It sits between the five router input ports (local IP core plus r1R, r2R, r1L, r2L) and the single routing engine of the router. Each port gets a one-entry holding slot. A round-robin scheduler forwards exactly one packet per cycle to the routing engine over a valid/ready handshake. Packets that collide at an occupied slot are dropped, flagged and counted, so that no packet is silently lost.

## Interface
Parameters:
- `N2`, default 9: packet width. Bit `N2-1` is the valid/emulation flag; the low `N2-1` bits are payload and are never interpreted here.
- `CW`, default 8: width of the drop counter.

Ports:
- `clk`, input, 1: single clock. All state updates on its rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_free`, input, `N2`: packet from the local IP core. Port index 0.
- `in_r1R`, `in_r2R`, `in_r1L`, `in_r2L`, input, `N2` each: packets from neighbour routers. Port indices 1, 2, 3, 4.
- `grant_pkt`, output, `N2`: packet presented to the routing engine.
- `grant_src`, output, 3: port index of `grant_pkt`.
- `grant_valid`, output, 1: `grant_pkt` and `grant_src` are valid.
- `grant_ready`, input, 1: routing engine accepts the packet this cycle.
- `hold_full`, output, 5: occupancy of each holding slot, bit = port index.
- `drop_err`, output, 5: sticky per-port drop flag.
- `drop_count`, output, `CW`: total drops across all ports, saturating.
- `clr_err`, input, 1: clears `drop_err` and `drop_count`.

## Operation
- Arrival: port p carries a packet in a cycle when `in_p[N2-1]` is 1. Each arriving packet is sampled on that cycle's edge.
- Slot load: the packet loads into slot p if slot p is empty, or if slot p is being moved to the output stage on the same edge.
- Drop: in every other case the packet is discarded, `drop_err[p]` is set, and `drop_count` increments.
  - `drop_count` increments by the number of ports that drop on that edge.
  - `drop_count` saturates at all-ones.
- Output stage: a single register holding `grant_pkt`, `grant_src` and `grant_valid`. It can load on an edge when it is empty, or when `grant_valid` and `grant_ready` are both 1 on that edge.
- Scheduler state: a pointer `last` (0..4).
  - When the output stage can load, the scheduler searches the occupied slots from `last+1` upward, wrapping mod 5.
  - The first occupied slot found moves to the output stage; that slot clears and `last` becomes its index.
  - If no slot is occupied, `grant_valid` goes 0 when the current packet is consumed.
- Stall: while `grant_valid` is 1 and `grant_ready` is 0, `grant_pkt` and `grant_src` hold constant and the slots are not drained.
- Error clear: `clr_err` clears `drop_err` and `drop_count` on the edge. A drop on the same edge wins: its flag bit is set, and `drop_count` equals the number of drops on that edge.
- Payload: the arbiter is payload-agnostic. Local packets carry a destination number; transit packets carry step counts in bits [7:4] and [3:0]. Both are forwarded unmodified.

## Timing
- Reset (asynchronous, `rst_n`=0) forces:
  - all slots empty, `hold_full`=0;
  - `grant_valid`=0, `grant_pkt`=0, `grant_src`=0;
  - `drop_err`=0, `drop_count`=0;
  - `last`=4, so port 0 has first priority.
- Reset mid-operation discards all held and in-flight packets. The first edge after `rst_n` rises behaves as a post-reset edge.
- Latency: a packet sampled at edge E0 sets `hold_full[p]` after E0. If the output stage is free at E1, `grant_valid`=1 after E1. Minimum latency is therefore 2 edges from sample to grant. There is no bypass path.
- Throughput: one grant per cycle while `grant_ready`=1 and any slot is occupied.
- Fairness: with k ports continuously occupied, each is served at least once every k grants.

## Test plan
- Reset: assert `rst_n`=0 mid-traffic. Required response: all outputs are 0 immediately, without waiting for a clock edge.
- Single packet: drive `in_r2R`=9'h121 for one cycle with `grant_ready`=1.
  - After the sampling edge: `hold_full`=5'b00100.
  - After the next edge: `grant_valid`=1, `grant_pkt`=9'h121, `grant_src`=2.
  - One cycle later: `grant_valid`=0.
- All five ports: drive all five with 9'h101..9'h105 on the same cycle, `grant_ready`=1. Required response: grants on consecutive cycles with `grant_src` 0, 1, 2, 3, 4; no drops.
- Round-robin: re-present ports 0 and 3 whenever their slot empties, `grant_ready`=1. Required response: `grant_src` alternates 0, 3, 0, 3 for at least 8 grants.
- Backpressure and drop: hold `grant_ready`=0 while port 0 sends 9'h1AA; port 1 then sends 9'h111 and, the next cycle, 9'h122.
  - Required: `grant_pkt`=9'h1AA stays stable throughout the stall.
  - The second port-1 packet drops: `drop_err`=5'b00010, `drop_count`=1.
  - Releasing `grant_ready` yields 9'h111 next.
- Clear versus drop: pulse `clr_err` on the same edge as a port-4 drop, with `drop_count`=3 beforehand. Required response: `drop_err`=5'b10000 and `drop_count`=1.
